// File: rtl/common_types.sv
// Shared CPU core types: data bytes, 6502 mnemonics and addressing modes.
// Imported by the decoder and by cpuunit, which consumes its outputs.
package common_types;

    typedef logic [7:0] data_t;

    // ILL marks any byte outside the documented NMOS 6502 set.
    typedef enum logic [5:0] {
        ILL,
        ADC, AND, ASL, BCC, BCS, BEQ, BIT, BMI,
        BNE, BPL, BRK, BVC, BVS, CLC, CLD, CLI,
        CLV, CMP, CPX, CPY, DEC, DEX, DEY, EOR,
        INC, INX, INY, JMP, JSR, LDA, LDX, LDY,
        LSR, NOP, ORA, PHA, PHP, PLA, PLP, ROL,
        ROR, RTI, RTS, SBC, SEC, SED, SEI, STA,
        STX, STY, TAX, TAY, TSX, TXA, TXS, TYA
    } opc_t;

    typedef enum logic [3:0] {
        IMP, ACC, IMM, ZP, ZPX, ZPY, ABS,
        ABSX, ABSY, IND, INDX, INDY, REL
    } addmod_t;

    typedef struct packed {
        opc_t    op;
        addmod_t mode;
    } dec_t;

endpackage

// File: rtl/instr_decode.sv
// Registered 6502 decoder: instr byte -> mnemonic, addressing mode, illegal.
// Ports: clk, rst (async, active-high), en, instr in; opcode, mode, illegal out.
module instr_decode
    import common_types::*;
(
    input  logic    clk,
    input  logic    rst,
    input  logic    en,
    input  data_t   instr,
    output opc_t    opcode,
    output addmod_t mode,
    output logic    illegal
);

    function automatic dec_t decode(input data_t b);
        dec_t d;
        case (b)
            8'h00: d = '{BRK, IMP};
            8'h01: d = '{ORA, INDX};
            8'h05: d = '{ORA, ZP};
            8'h06: d = '{ASL, ZP};
            8'h08: d = '{PHP, IMP};
            8'h09: d = '{ORA, IMM};
            8'h0A: d = '{ASL, ACC};
            8'h0D: d = '{ORA, ABS};
            8'h0E: d = '{ASL, ABS};
            8'h10: d = '{BPL, REL};
            8'h11: d = '{ORA, INDY};
            8'h15: d = '{ORA, ZPX};
            8'h16: d = '{ASL, ZPX};
            8'h18: d = '{CLC, IMP};
            8'h19: d = '{ORA, ABSY};
            8'h1D: d = '{ORA, ABSX};
            8'h1E: d = '{ASL, ABSX};
            8'h20: d = '{JSR, ABS};
            8'h21: d = '{AND, INDX};
            8'h24: d = '{BIT, ZP};
            8'h25: d = '{AND, ZP};
            8'h26: d = '{ROL, ZP};
            8'h28: d = '{PLP, IMP};
            8'h29: d = '{AND, IMM};
            8'h2A: d = '{ROL, ACC};
            8'h2C: d = '{BIT, ABS};
            8'h2D: d = '{AND, ABS};
            8'h2E: d = '{ROL, ABS};
            8'h30: d = '{BMI, REL};
            8'h31: d = '{AND, INDY};
            8'h35: d = '{AND, ZPX};
            8'h36: d = '{ROL, ZPX};
            8'h38: d = '{SEC, IMP};
            8'h39: d = '{AND, ABSY};
            8'h3D: d = '{AND, ABSX};
            8'h3E: d = '{ROL, ABSX};
            8'h40: d = '{RTI, IMP};
            8'h41: d = '{EOR, INDX};
            8'h45: d = '{EOR, ZP};
            8'h46: d = '{LSR, ZP};
            8'h48: d = '{PHA, IMP};
            8'h49: d = '{EOR, IMM};
            8'h4A: d = '{LSR, ACC};
            8'h4C: d = '{JMP, ABS};
            8'h4D: d = '{EOR, ABS};
            8'h4E: d = '{LSR, ABS};
            8'h50: d = '{BVC, REL};
            8'h51: d = '{EOR, INDY};
            8'h55: d = '{EOR, ZPX};
            8'h56: d = '{LSR, ZPX};
            8'h58: d = '{CLI, IMP};
            8'h59: d = '{EOR, ABSY};
            8'h5D: d = '{EOR, ABSX};
            8'h5E: d = '{LSR, ABSX};
            8'h60: d = '{RTS, IMP};
            8'h61: d = '{ADC, INDX};
            8'h65: d = '{ADC, ZP};
            8'h66: d = '{ROR, ZP};
            8'h68: d = '{PLA, IMP};
            8'h69: d = '{ADC, IMM};
            8'h6A: d = '{ROR, ACC};
            8'h6C: d = '{JMP, IND};
            8'h6D: d = '{ADC, ABS};
            8'h6E: d = '{ROR, ABS};
            8'h70: d = '{BVS, REL};
            8'h71: d = '{ADC, INDY};
            8'h75: d = '{ADC, ZPX};
            8'h76: d = '{ROR, ZPX};
            8'h78: d = '{SEI, IMP};
            8'h79: d = '{ADC, ABSY};
            8'h7D: d = '{ADC, ABSX};
            8'h7E: d = '{ROR, ABSX};
            8'h81: d = '{STA, INDX};
            8'h84: d = '{STY, ZP};
            8'h85: d = '{STA, ZP};
            8'h86: d = '{STX, ZP};
            8'h88: d = '{DEY, IMP};
            8'h8A: d = '{TXA, IMP};
            8'h8C: d = '{STY, ABS};
            8'h8D: d = '{STA, ABS};
            8'h8E: d = '{STX, ABS};
            8'h90: d = '{BCC, REL};
            8'h91: d = '{STA, INDY};
            8'h94: d = '{STY, ZPX};
            8'h95: d = '{STA, ZPX};
            8'h96: d = '{STX, ZPY};
            8'h98: d = '{TYA, IMP};
            8'h99: d = '{STA, ABSY};
            8'h9A: d = '{TXS, IMP};
            8'h9D: d = '{STA, ABSX};
            8'hA0: d = '{LDY, IMM};
            8'hA1: d = '{LDA, INDX};
            8'hA2: d = '{LDX, IMM};
            8'hA4: d = '{LDY, ZP};
            8'hA5: d = '{LDA, ZP};
            8'hA6: d = '{LDX, ZP};
            8'hA8: d = '{TAY, IMP};
            8'hA9: d = '{LDA, IMM};
            8'hAA: d = '{TAX, IMP};
            8'hAC: d = '{LDY, ABS};
            8'hAD: d = '{LDA, ABS};
            8'hAE: d = '{LDX, ABS};
            8'hB0: d = '{BCS, REL};
            8'hB1: d = '{LDA, INDY};
            8'hB4: d = '{LDY, ZPX};
            8'hB5: d = '{LDA, ZPX};
            8'hB6: d = '{LDX, ZPY};
            8'hB8: d = '{CLV, IMP};
            8'hB9: d = '{LDA, ABSY};
            8'hBA: d = '{TSX, IMP};
            8'hBC: d = '{LDY, ABSX};
            8'hBD: d = '{LDA, ABSX};
            8'hBE: d = '{LDX, ABSY};
            8'hC0: d = '{CPY, IMM};
            8'hC1: d = '{CMP, INDX};
            8'hC4: d = '{CPY, ZP};
            8'hC5: d = '{CMP, ZP};
            8'hC6: d = '{DEC, ZP};
            8'hC8: d = '{INY, IMP};
            8'hC9: d = '{CMP, IMM};
            8'hCA: d = '{DEX, IMP};
            8'hCC: d = '{CPY, ABS};
            8'hCD: d = '{CMP, ABS};
            8'hCE: d = '{DEC, ABS};
            8'hD0: d = '{BNE, REL};
            8'hD1: d = '{CMP, INDY};
            8'hD5: d = '{CMP, ZPX};
            8'hD6: d = '{DEC, ZPX};
            8'hD8: d = '{CLD, IMP};
            8'hD9: d = '{CMP, ABSY};
            8'hDD: d = '{CMP, ABSX};
            8'hDE: d = '{DEC, ABSX};
            8'hE0: d = '{CPX, IMM};
            8'hE1: d = '{SBC, INDX};
            8'hE4: d = '{CPX, ZP};
            8'hE5: d = '{SBC, ZP};
            8'hE6: d = '{INC, ZP};
            8'hE8: d = '{INX, IMP};
            8'hE9: d = '{SBC, IMM};
            8'hEA: d = '{NOP, IMP};
            8'hEC: d = '{CPX, ABS};
            8'hED: d = '{SBC, ABS};
            8'hEE: d = '{INC, ABS};
            8'hF0: d = '{BEQ, REL};
            8'hF1: d = '{SBC, INDY};
            8'hF5: d = '{SBC, ZPX};
            8'hF6: d = '{INC, ZPX};
            8'hF8: d = '{SED, IMP};
            8'hF9: d = '{SBC, ABSY};
            8'hFD: d = '{SBC, ABSX};
            8'hFE: d = '{INC, ABSX};
            default: d = '{ILL, IMP};
        endcase
        return d;
    endfunction

    opc_t    opcode_d, opcode_q;
    addmod_t mode_d,   mode_q;
    logic    illegal_d, illegal_q;
    dec_t    dec;

    always_comb begin
        dec       = decode(instr);
        opcode_d  = opcode_q;
        mode_d    = mode_q;
        illegal_d = illegal_q;
        if (en) begin
            opcode_d  = dec.op;
            mode_d    = dec.mode;
            illegal_d = (dec.op == ILL);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            opcode_q  <= NOP;
            mode_q    <= IMP;
            illegal_q <= 1'b0;
        end else begin
            opcode_q  <= opcode_d;
            mode_q    <= mode_d;
            illegal_q <= illegal_d;
        end
    end

    assign opcode  = opcode_q;
    assign mode    = mode_q;
    assign illegal = illegal_q;

endmodule

// File: tb/tb_instr_decode.sv
// Self-checking bench for instr_decode: directed vectors, reset/hold
// sequences and a full 256-byte sweep against an opcode-matrix model.
module tb_instr_decode;
    import common_types::*;

    logic    clk;
    logic    rst;
    logic    en;
    data_t   instr;
    opc_t    opcode;
    addmod_t mode;
    logic    illegal;

    int errors = 0;
    int checks = 0;

    instr_decode dut (
        .clk     (clk),
        .rst     (rst),
        .en      (en),
        .instr   (instr),
        .opcode  (opcode),
        .mode    (mode),
        .illegal (illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic    en;
        data_t   instr;
        opc_t    op;
        addmod_t md;
        logic    ill;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string nm, input opc_t eo,
                       input addmod_t em, input logic ei);
        checks++;
        if (opcode !== eo || mode !== em || illegal !== ei) begin
            errors++;
            $display("FAIL %s: got %s/%s/%b want %s/%s/%b", nm,
                     opcode.name(), mode.name(), illegal,
                     eo.name(), em.name(), ei);
        end
    endtask

    // Reference built from the aaabbbcc structure of the 6502 matrix.
    function automatic void gold(input data_t b, output opc_t op,
                                 output addmod_t m);
        logic [2:0] a;
        logic [2:0] bb;
        logic [1:0] c;
        logic ok;
        logic xy;
        a  = b[7:5];
        bb = b[4:2];
        c  = b[1:0];
        op = ILL;
        m  = IMP;
        ok = 1'b1;
        xy = (a == 3'd4) || (a == 3'd5);
        case (c)
            2'b01: begin
                case (a)
                    3'd0: op = ORA;
                    3'd1: op = AND;
                    3'd2: op = EOR;
                    3'd3: op = ADC;
                    3'd4: op = STA;
                    3'd5: op = LDA;
                    3'd6: op = CMP;
                    default: op = SBC;
                endcase
                case (bb)
                    3'd0: m = INDX;
                    3'd1: m = ZP;
                    3'd2: m = IMM;
                    3'd3: m = ABS;
                    3'd4: m = INDY;
                    3'd5: m = ZPX;
                    3'd6: m = ABSY;
                    default: m = ABSX;
                endcase
                if (b == 8'h89) ok = 1'b0;
            end
            2'b10: begin
                case (a)
                    3'd0: op = ASL;
                    3'd1: op = ROL;
                    3'd2: op = LSR;
                    3'd3: op = ROR;
                    3'd4: op = STX;
                    3'd5: op = LDX;
                    3'd6: op = DEC;
                    default: op = INC;
                endcase
                case (bb)
                    3'd0: begin m = IMM; ok = (a == 3'd5); end
                    3'd1: m = ZP;
                    3'd2: begin
                        if (a < 3'd4) m = ACC;
                        else begin
                            m = IMP;
                            case (a)
                                3'd4: op = TXA;
                                3'd5: op = TAX;
                                3'd6: op = DEX;
                                default: op = NOP;
                            endcase
                        end
                    end
                    3'd3: m = ABS;
                    3'd4: ok = 1'b0;
                    3'd5: m = xy ? ZPY : ZPX;
                    3'd6: begin
                        m = IMP;
                        if (a == 3'd4) op = TXS;
                        else if (a == 3'd5) op = TSX;
                        else ok = 1'b0;
                    end
                    default: begin
                        m = xy ? ABSY : ABSX;
                        if (a == 3'd4) ok = 1'b0;
                    end
                endcase
            end
            2'b00: begin
                case (bb)
                    3'd0: begin
                        case (a)
                            3'd0: op = BRK;
                            3'd1: begin op = JSR; m = ABS; end
                            3'd2: op = RTI;
                            3'd3: op = RTS;
                            3'd4: ok = 1'b0;
                            3'd5: begin op = LDY; m = IMM; end
                            3'd6: begin op = CPY; m = IMM; end
                            default: begin op = CPX; m = IMM; end
                        endcase
                    end
                    3'd1, 3'd3: begin
                        m = (bb == 3'd1) ? ZP : ABS;
                        case (a)
                            3'd1: op = BIT;
                            3'd2: op = JMP;
                            3'd3: begin op = JMP; m = IND; end
                            3'd4: op = STY;
                            3'd5: op = LDY;
                            3'd6: op = CPY;
                            3'd7: op = CPX;
                            default: ok = 1'b0;
                        endcase
                        if (bb == 3'd1 && (a == 3'd2 || a == 3'd3))
                            ok = 1'b0;
                    end
                    3'd2: begin
                        case (a)
                            3'd0: op = PHP;
                            3'd1: op = PLP;
                            3'd2: op = PHA;
                            3'd3: op = PLA;
                            3'd4: op = DEY;
                            3'd5: op = TAY;
                            3'd6: op = INY;
                            default: op = INX;
                        endcase
                    end
                    3'd4: begin
                        m = REL;
                        case (a)
                            3'd0: op = BPL;
                            3'd1: op = BMI;
                            3'd2: op = BVC;
                            3'd3: op = BVS;
                            3'd4: op = BCC;
                            3'd5: op = BCS;
                            3'd6: op = BNE;
                            default: op = BEQ;
                        endcase
                    end
                    3'd5: begin
                        m = ZPX;
                        if (a == 3'd4) op = STY;
                        else if (a == 3'd5) op = LDY;
                        else ok = 1'b0;
                    end
                    3'd6: begin
                        case (a)
                            3'd0: op = CLC;
                            3'd1: op = SEC;
                            3'd2: op = CLI;
                            3'd3: op = SEI;
                            3'd4: op = TYA;
                            3'd5: op = CLV;
                            3'd6: op = CLD;
                            default: op = SED;
                        endcase
                    end
                    default: begin
                        m = ABSX;
                        if (a == 3'd5) op = LDY;
                        else ok = 1'b0;
                    end
                endcase
            end
            default: ok = 1'b0;
        endcase
        if (!ok) begin
            op = ILL;
            m  = IMP;
        end
    endfunction

    task automatic apply(input logic e, input data_t b);
        @(negedge clk);
        en    = e;
        instr = b;
        @(posedge clk);
        #1;
    endtask

    initial begin
        opc_t    gop;
        addmod_t gmd;
        int      legal;

        vecs.push_back('{1'b1, 8'hE8, INX, IMP,  1'b0});
        vecs.push_back('{1'b1, 8'hA2, LDX, IMM,  1'b0});
        vecs.push_back('{1'b1, 8'hA6, LDX, ZP,   1'b0});
        vecs.push_back('{1'b1, 8'h4C, JMP, ABS,  1'b0});
        vecs.push_back('{1'b1, 8'hF0, BEQ, REL,  1'b0});
        vecs.push_back('{1'b1, 8'h6C, JMP, IND,  1'b0});
        vecs.push_back('{1'b1, 8'h0A, ASL, ACC,  1'b0});
        vecs.push_back('{1'b1, 8'hB1, LDA, INDY, 1'b0});
        vecs.push_back('{1'b1, 8'hB6, LDX, ZPY,  1'b0});
        vecs.push_back('{1'b1, 8'hBE, LDX, ABSY, 1'b0});
        vecs.push_back('{1'b1, 8'h02, ILL, IMP,  1'b1});
        vecs.push_back('{1'b1, 8'hEA, NOP, IMP,  1'b0});
        vecs.push_back('{1'b1, 8'hA9, LDA, IMM,  1'b0});
        vecs.push_back('{1'b0, 8'h00, LDA, IMM,  1'b0});
        vecs.push_back('{1'b0, 8'h00, LDA, IMM,  1'b0});
        vecs.push_back('{1'b0, 8'hFF, LDA, IMM,  1'b0});
        vecs.push_back('{1'b1, 8'hFF, ILL, IMP,  1'b1});
        vecs.push_back('{1'b1, 8'h96, STX, ZPY,  1'b0});

        rst   = 1'b1;
        en    = 1'b1;
        instr = 8'hE8;
        #1;
        chk("reset_async", NOP, IMP, 1'b0);
        @(posedge clk);
        #1;
        chk("reset_held", NOP, IMP, 1'b0);

        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("reset_release", NOP, IMP, 1'b0);

        foreach (vecs[i]) begin
            apply(vecs[i].en, vecs[i].instr);
            chk($sformatf("vec%0d_%02h", i, vecs[i].instr),
                vecs[i].op, vecs[i].md, vecs[i].ill);
        end

        @(negedge clk);
        #2;
        rst   = 1'b1;
        en    = 1'b1;
        instr = 8'hA9;
        #1;
        chk("midstream_reset", NOP, IMP, 1'b0);
        @(posedge clk);
        #1;
        chk("reset_ignores_en", NOP, IMP, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("after_reset_A9", LDA, IMM, 1'b0);

        legal = 0;
        for (int b = 0; b < 256; b++) begin
            apply(1'b1, data_t'(b));
            gold(data_t'(b), gop, gmd);
            chk($sformatf("sweep_%02h", b), gop, gmd, gop == ILL);
            if (!illegal) legal++;
        end
        checks++;
        if (legal != 151) begin
            errors++;
            $display("FAIL legal_count: got %0d want 151", legal);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
